// File: rtl/pkt_spi_read_if.sv
// Bus bundle for the SPI readback path: simple-bus read side plus the packet
// FIFO read port. The master side is the host/FIFO environment; the slave side is the block.
interface pkt_spi_read_if;
    logic [7:0] sb_addr;
    logic       sb_addr_stb;
    logic       sb_strobe;
    logic       sb_last;
    logic [7:0] sb_rdata;
    logic       sb_rsel;
    logic [7:0] fifo_data;
    logic       fifo_last;
    logic       fifo_empty;
    logic       fifo_rden;

    modport master (
        output sb_addr, sb_addr_stb, sb_strobe, sb_last,
        output fifo_data, fifo_last, fifo_empty,
        input  sb_rdata, sb_rsel, fifo_rden
    );

    modport slave (
        input  sb_addr, sb_addr_stb, sb_strobe, sb_last,
        input  fifo_data, fifo_last, fifo_empty,
        output sb_rdata, sb_rsel, fifo_rden
    );
endinterface

// File: rtl/pkt_spi_read.sv
// SPI readback path: drains framed packets from a show-ahead FIFO and serves
// them byte-by-byte over the simple-bus read side, with a byte-count/status register.
module pkt_spi_read #(
    parameter logic [7:0] BASE   = 8'h30,
    parameter int         CWIDTH = 10
) (
    input logic          clk,
    input logic          rst_n,
    pkt_spi_read_if.slave bus
);

    // state  | meaning
    // IDLE   | no transaction in progress
    // D_HDR  | DATA read, header byte being shifted
    // D_DATA | DATA read, packet bytes being served
    // D_PAD  | DATA read, packet done or nothing to send; pad with zeros
    // S_HI   | STATUS read, flags/count-high byte being shifted
    // S_LO   | STATUS read, count-low byte being shifted
    // S_PAD  | STATUS read, pad with zeros
    // OTHER  | transaction addressed elsewhere
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] D_HDR  = 3'd1;
    localparam logic [2:0] D_DATA = 3'd2;
    localparam logic [2:0] D_PAD  = 3'd3;
    localparam logic [2:0] S_HI   = 3'd4;
    localparam logic [2:0] S_LO   = 3'd5;
    localparam logic [2:0] S_PAD  = 3'd6;
    localparam logic [2:0] OTHER  = 3'd7;

    localparam logic [7:0]        STAT_ADDR = BASE + 8'd1;
    localparam logic [CWIDTH-1:0] CNT_MAX   = {CWIDTH{1'b1}};

    logic [2:0]        state;
    logic [7:0]        rdata;
    logic              rsel;
    logic              rden;
    logic              mid;
    logic              eop;
    logic              urun;
    logic [CWIDTH-1:0] cnt;

    assign bus.sb_rdata  = rdata;
    assign bus.sb_rsel   = rsel;
    assign bus.fifo_rden = rden;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rdata <= 8'h00;
            rsel  <= 1'b0;
            rden  <= 1'b0;
            mid   <= 1'b0;
            eop   <= 1'b0;
            urun  <= 1'b0;
            cnt   <= '0;
        end else begin
            rden <= 1'b0;
            // An address strobe starts a new transaction and masks any coincident slot strobe.
            if (bus.sb_addr_stb) begin
                if (bus.sb_addr == BASE) begin
                    cnt   <= '0;
                    eop   <= 1'b0;
                    rdata <= {~bus.fifo_empty, mid, 6'b0};
                    rsel  <= 1'b1;
                    state <= D_HDR;
                end else if (bus.sb_addr == STAT_ADDR) begin
                    rdata <= {eop, urun, {(14-CWIDTH){1'b0}}, cnt[CWIDTH-1:8]};
                    urun  <= 1'b0;
                    rsel  <= 1'b1;
                    state <= S_HI;
                end else begin
                    rdata <= 8'h00;
                    rsel  <= 1'b0;
                    state <= OTHER;
                end
            end else if (bus.sb_strobe) begin
                case (state)
                    D_HDR, D_DATA: begin
                        if (!bus.fifo_empty) begin
                            rdata <= bus.fifo_data;
                            rden  <= 1'b1;
                            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                            mid   <= ~bus.fifo_last;
                            if (bus.fifo_last) begin
                                eop   <= 1'b1;
                                state <= D_PAD;
                            end else begin
                                state <= D_DATA;
                            end
                        end else if (mid) begin
                            urun  <= 1'b1;
                            rdata <= 8'h00;
                        end else begin
                            rdata <= 8'h00;
                            state <= D_PAD;
                        end
                    end
                    S_HI: begin
                        rdata <= cnt[7:0];
                        state <= S_LO;
                    end
                    S_LO, S_PAD: begin
                        rdata <= 8'h00;
                        state <= S_PAD;
                    end
                    default: rdata <= 8'h00;
                endcase
                // Final slot: the slot action above still applies, then release the bus.
                if (bus.sb_last) begin
                    rsel  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_spi_read.sv
// Directed bench for pkt_spi_read: scripted SPI transactions against a queue-based FIFO model.
module tb_pkt_spi_read;
    localparam logic [7:0] BASE = 8'h30;
    localparam logic [7:0] STAT = 8'h31;

    logic clk;
    logic rst_n;
    pkt_spi_read_if bus ();

    pkt_spi_read #(.BASE(BASE), .CWIDTH(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int pop_empty = 0;
    logic [8:0] q[$];
    logic [7:0] got [8];
    logic       rsel_in;
    logic       rsel_end;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        bus.fifo_empty = (q.size() == 0);
        if (q.size() != 0) begin
            bus.fifo_data = q[0][7:0];
            bus.fifo_last = q[0][8];
        end else begin
            bus.fifo_data = 8'h00;
            bus.fifo_last = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        q.push_back({l, d});
        refresh();
    endtask

    // FIFO model: pop on each registered read pulse.
    always @(posedge clk) begin
        if (bus.fifo_rden === 1'b1) begin
            pops++;
            if (q.size() == 0) pop_empty++;
            else void'(q.pop_front());
            refresh();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic strobe(input logic last);
        bus.sb_strobe = 1'b1;
        bus.sb_last   = last;
        tick();
        bus.sb_strobe = 1'b0;
        bus.sb_last   = 1'b0;
    endtask

    task automatic addr_stb(input logic [7:0] a);
        bus.sb_addr     = a;
        bus.sb_addr_stb = 1'b1;
        tick();
        bus.sb_addr_stb = 1'b0;
    endtask

    // n slots: byte 0 is served after the address, bytes 1..n-1 after each slot strobe.
    task automatic run_txn(input logic [7:0] a, input int n);
        addr_stb(a);
        got[0]  = bus.sb_rdata;
        rsel_in = bus.sb_rsel;
        tick();
        for (int i = 1; i <= n; i++) begin
            strobe(i == n);
            if (i < n) got[i] = bus.sb_rdata;
            tick();
        end
        rsel_end = bus.sb_rsel;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (bus.sb_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bus.sb_rdata); end
        checks++;
        if (bus.sb_rsel !== 1'b0) begin errors++; $display("FAIL reset_rsel got %b want 0", bus.sb_rsel); end
        checks++;
        if (bus.fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", bus.fifo_rden); end
    endtask

    task automatic test_status_after_reset();
        run_txn(STAT, 2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== 8'h00) begin errors++; $display("FAIL stat0_b%0d got %h want 00", i, got[i]); end
        end
        checks++;
        if (rsel_in !== 1'b1) begin errors++; $display("FAIL stat0_rsel_in got %b want 1", rsel_in); end
        checks++;
        if (rsel_end !== 1'b0) begin errors++; $display("FAIL stat0_rsel_end got %b want 0", rsel_end); end
    endtask

    task automatic test_full_packet();
        logic [47:0] ev;
        int p0;
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
        p0 = pops;
        run_txn(BASE, 6);
        ev = 48'h80_11_22_33_00_00;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== ev[8*(5-i) +: 8]) begin errors++; $display("FAIL full_b%0d got %h want %h", i, got[i], ev[8*(5-i) +: 8]); end
        end
        checks++;
        if (pops - p0 !== 3) begin errors++; $display("FAIL full_pops got %0d want 3", pops - p0); end
        checks++;
        if (rsel_end !== 1'b0) begin errors++; $display("FAIL full_rsel_end got %b want 0", rsel_end); end
        run_txn(STAT, 2);
        checks++;
        if (got[0] !== 8'h80) begin errors++; $display("FAIL full_stat_hi got %h want 80", got[0]); end
        checks++;
        if (got[1] !== 8'h03) begin errors++; $display("FAIL full_stat_lo got %h want 03", got[1]); end
    endtask

    // The final slot strobe still pops: 33 is consumed and lost, so the
    // continuation resumes at 44.
    task automatic test_split_packet();
        logic [31:0] ev;
        int p0;
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0); push(8'h55, 1);
        p0 = pops;
        run_txn(BASE, 3);
        ev = 32'h80_11_22_00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== ev[8*(3-i) +: 8]) begin errors++; $display("FAIL split1_b%0d got %h want %h", i, got[i], ev[8*(3-i) +: 8]); end
        end
        checks++;
        if (pops - p0 !== 3) begin errors++; $display("FAIL split1_pops got %0d want 3", pops - p0); end
        p0 = pops;
        run_txn(BASE, 4);
        ev = 32'hC0_44_55_00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== ev[8*(3-i) +: 8]) begin errors++; $display("FAIL split2_b%0d got %h want %h", i, got[i], ev[8*(3-i) +: 8]); end
        end
        checks++;
        if (pops - p0 !== 2) begin errors++; $display("FAIL split2_pops got %0d want 2", pops - p0); end
        run_txn(STAT, 2);
        checks++;
        if (got[0] !== 8'h80 || got[1] !== 8'h02) begin errors++; $display("FAIL split_stat got %h%h want 8002", got[0], got[1]); end
    endtask

    task automatic test_underrun();
        logic [39:0] ev;
        int p0;
        push(8'hAA, 0); push(8'hBB, 0);
        p0 = pops;
        run_txn(BASE, 5);
        ev = 40'h80_AA_BB_00_00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== ev[8*(4-i) +: 8]) begin errors++; $display("FAIL urun_b%0d got %h want %h", i, got[i], ev[8*(4-i) +: 8]); end
        end
        checks++;
        if (pops - p0 !== 2) begin errors++; $display("FAIL urun_pops got %0d want 2", pops - p0); end
        run_txn(STAT, 2);
        checks++;
        if (got[0] !== 8'h40 || got[1] !== 8'h02) begin errors++; $display("FAIL urun_stat1 got %h%h want 4002", got[0], got[1]); end
        run_txn(STAT, 2);
        checks++;
        if (got[0] !== 8'h00 || got[1] !== 8'h02) begin errors++; $display("FAIL urun_stat2 got %h%h want 0002", got[0], got[1]); end
    endtask

    task automatic test_empty();
        int p0;
        reset_dut();
        p0 = pops;
        run_txn(BASE, 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== 8'h00) begin errors++; $display("FAIL empty_b%0d got %h want 00", i, got[i]); end
        end
        checks++;
        if (pops - p0 !== 0) begin errors++; $display("FAIL empty_pops got %0d want 0", pops - p0); end
        run_txn(STAT, 2);
        checks++;
        if (got[0] !== 8'h00 || got[1] !== 8'h00) begin errors++; $display("FAIL empty_stat got %h%h want 0000", got[0], got[1]); end
    endtask

    task automatic test_other_addr();
        push(8'h66, 1);
        run_txn(8'h55, 2);
        checks++;
        if (rsel_in !== 1'b0) begin errors++; $display("FAIL other_rsel got %b want 0", rsel_in); end
        checks++;
        if (got[0] !== 8'h00 || got[1] !== 8'h00) begin errors++; $display("FAIL other_data got %h%h want 0000", got[0], got[1]); end
    endtask

    task automatic test_addr_wins();
        int p0;
        p0 = pops;
        bus.sb_addr     = BASE;
        bus.sb_addr_stb = 1'b1;
        bus.sb_strobe   = 1'b1;
        tick();
        bus.sb_addr_stb = 1'b0;
        bus.sb_strobe   = 1'b0;
        checks++;
        if (bus.sb_rdata !== 8'h80) begin errors++; $display("FAIL addrwin_hdr got %h want 80", bus.sb_rdata); end
        tick();
        tick();
        checks++;
        if (pops - p0 !== 0) begin errors++; $display("FAIL addrwin_pops got %0d want 0", pops - p0); end
        strobe(0);
        checks++;
        if (bus.sb_rdata !== 8'h66) begin errors++; $display("FAIL addrwin_b1 got %h want 66", bus.sb_rdata); end
        tick();
        strobe(1);
        tick();
        checks++;
        if (bus.sb_rsel !== 1'b0) begin errors++; $display("FAIL addrwin_rsel_end got %b want 0", bus.sb_rsel); end
    endtask

    task automatic test_reset_mid();
        int p0;
        push(8'hD1, 0); push(8'hD2, 0); push(8'hD3, 0); push(8'hD4, 1);
        p0 = pops;
        addr_stb(BASE);
        tick();
        strobe(0); tick();
        strobe(0);
        checks++;
        if (bus.sb_rdata !== 8'hD2) begin errors++; $display("FAIL rmid_b2 got %h want D2", bus.sb_rdata); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.sb_rsel !== 1'b0 || bus.sb_rdata !== 8'h00) begin errors++; $display("FAIL rmid_after_rst got rsel %b data %h want 0 00", bus.sb_rsel, bus.sb_rdata); end
        strobe(0);
        checks++;
        if (bus.sb_rsel !== 1'b0 || bus.sb_rdata !== 8'h00) begin errors++; $display("FAIL rmid_b3 got rsel %b data %h want 0 00", bus.sb_rsel, bus.sb_rdata); end
        tick();
        strobe(1); tick();
        checks++;
        if (pops - p0 !== 2) begin errors++; $display("FAIL rmid_pops got %0d want 2", pops - p0); end
        run_txn(BASE, 3);
        checks++;
        if (got[0] !== 8'h80) begin errors++; $display("FAIL rmid_hdr got %h want 80", got[0]); end
        checks++;
        if (got[1] !== 8'hD3 || got[2] !== 8'hD4) begin errors++; $display("FAIL rmid_data got %h%h want D3D4", got[1], got[2]); end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.sb_addr     = 8'h00;
        bus.sb_addr_stb = 1'b0;
        bus.sb_strobe   = 1'b0;
        bus.sb_last     = 1'b0;
        refresh();
        test_reset();
        test_status_after_reset();
        test_full_packet();
        test_split_packet();
        test_underrun();
        test_empty();
        test_other_addr();
        test_addr_wins();
        test_reset_mid();
        checks++;
        if (pop_empty !== 0) begin errors++; $display("FAIL pop_on_empty got %0d want 0", pop_empty); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
